// File: rtl/map_pkg.sv
// Shared map definitions: geometry, block ids, address packing and controller states.
package map_pkg;

    localparam int unsigned MAP_BITS   = 5;
    localparam int unsigned MAP_ADDR_W = 15;
    localparam int unsigned BLOCK_ID_W = 5;

    localparam logic [BLOCK_ID_W-1:0] AIR     = 5'd0;
    localparam logic [BLOCK_ID_W-1:0] BEDROCK = 5'd1;
    localparam logic [BLOCK_ID_W-1:0] STONE   = 5'd2;
    localparam logic [BLOCK_ID_W-1:0] DIRT    = 5'd3;
    localparam logic [BLOCK_ID_W-1:0] GRASS   = 5'd4;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    // Map RAM is z-major: addr = z*1024 + y*32 + x.
    function automatic logic [MAP_ADDR_W-1:0] pack_addr(
        input logic [MAP_BITS-1:0] x,
        input logic [MAP_BITS-1:0] y,
        input logic [MAP_BITS-1:0] z
    );
        return {z, y, x};
    endfunction

endpackage

// File: rtl/terrain_gen.sv
// Layered procedural terrain: maps a column height z to the block id stored there.
module terrain_gen
    import map_pkg::*;
#(
    parameter logic [BLOCK_ID_W-1:0] BEDROCK_ID = BEDROCK,
    parameter logic [BLOCK_ID_W-1:0] STONE_ID   = STONE,
    parameter logic [BLOCK_ID_W-1:0] DIRT_ID    = DIRT,
    parameter logic [BLOCK_ID_W-1:0] GRASS_ID   = GRASS,
    parameter logic [MAP_BITS-1:0]   STONE_TOP  = 5'd8,
    parameter logic [MAP_BITS-1:0]   DIRT_TOP   = 5'd11
) (
    input  logic [MAP_BITS-1:0]   z,
    output logic [BLOCK_ID_W-1:0] block_id
);

    always_comb begin
        block_id = AIR;
        if (z == '0)
            block_id = BEDROCK_ID;
        else if (z < STONE_TOP)
            block_id = STONE_ID;
        else if (z < DIRT_TOP)
            block_id = DIRT_ID;
        else if (z == DIRT_TOP)
            block_id = GRASS_ID;
    end

endmodule

// File: rtl/map_writer.sv
// Write-side controller for the voxel map RAM: power-up terrain fill, then
// place/break commands over a valid/ready handshake, one RAM write each.
module map_writer
    import map_pkg::*;
#(
    parameter logic [BLOCK_ID_W-1:0] BEDROCK_ID = BEDROCK,
    parameter logic [BLOCK_ID_W-1:0] STONE_ID   = STONE,
    parameter logic [BLOCK_ID_W-1:0] DIRT_ID    = DIRT,
    parameter logic [BLOCK_ID_W-1:0] GRASS_ID   = GRASS,
    parameter logic [MAP_BITS-1:0]   STONE_TOP  = 5'd8,
    parameter logic [MAP_BITS-1:0]   DIRT_TOP   = 5'd11,
    parameter logic [BLOCK_ID_W-1:0] MAX_ID     = 5'd15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_start,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MAP_BITS-1:0]   cmd_x,
    input  logic [MAP_BITS-1:0]   cmd_y,
    input  logic [MAP_BITS-1:0]   cmd_z,
    input  logic [BLOCK_ID_W-1:0] cmd_id,
    output logic                  cmd_err,
    output logic                  busy,
    output logic [MAP_ADDR_W-1:0] write_addr,
    output logic [BLOCK_ID_W-1:0] write_data,
    output logic                  write_en
);

    state_t                  state;
    logic [MAP_ADDR_W-1:0]   cnt;
    logic [MAP_ADDR_W-1:0]   fill_addr;
    logic [BLOCK_ID_W-1:0]   fill_id;
    logic                    xfer;
    logic                    cmd_bad;

    // A fill restart writes address 0 on the very next edge, so the counter
    // value is overridden here rather than being cleared a cycle late.
    assign fill_addr = fill_start ? '0 : cnt;

    terrain_gen #(
        .BEDROCK_ID (BEDROCK_ID),
        .STONE_ID   (STONE_ID),
        .DIRT_ID    (DIRT_ID),
        .GRASS_ID   (GRASS_ID),
        .STONE_TOP  (STONE_TOP),
        .DIRT_TOP   (DIRT_TOP)
    ) u_terrain (
        .z        (fill_addr[MAP_ADDR_W-1 -: MAP_BITS]),
        .block_id (fill_id)
    );

    assign cmd_ready = (state == READY) && !fill_start;
    assign xfer      = cmd_valid && cmd_ready;
    // Bedrock layer is immutable, including breaks.
    assign cmd_bad   = (cmd_z == '0) || (cmd_id > MAX_ID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            cnt        <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            cmd_err    <= 1'b0;
            busy       <= 1'b1;
        end else if (state == FILL) begin
            busy       <= 1'b1;
            cmd_err    <= 1'b0;
            write_en   <= 1'b1;
            write_addr <= fill_addr;
            write_data <= fill_id;
            cnt        <= fill_addr + 1'b1;
            if (fill_addr == '1)
                state <= READY;
        end else if (fill_start) begin
            state    <= FILL;
            cnt      <= '0;
            busy     <= 1'b1;
            write_en <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            busy <= 1'b0;
            if (xfer && !cmd_bad) begin
                write_en   <= 1'b1;
                write_addr <= pack_addr(cmd_x, cmd_y, cmd_z);
                write_data <= cmd_id;
                cmd_err    <= 1'b0;
            end else begin
                write_en <= 1'b0;
                cmd_err  <= xfer;
            end
        end
    end

endmodule
